// File: rtl/acc_requant_writeback.sv
// Requantization writeback: bias add, rounding shift, int8 saturation and optional ReLU,
// then sequential writes of one w x h output map into the feature-map RAM.
module acc_requant_writeback #(
  parameter int ACC_WIDTH   = 26,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int BIAS_WIDTH  = 16,
  parameter int DIM_WIDTH   = 6,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [DIM_WIDTH-1:0]   cfg_out_w,
  input  logic [DIM_WIDTH-1:0]   cfg_out_h,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic [BIAS_WIDTH-1:0]  cfg_bias,
  input  logic                   cfg_relu_en,
  input  logic                   acc_valid,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  output logic                   acc_ready,
  input  logic                   wr_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sat_cnt
);

  localparam int CNT_WIDTH = 2 * DIM_WIDTH;
  localparam int SUM_WIDTH = ACC_WIDTH + 1;
  localparam int RND_WIDTH = ACC_WIDTH + 2;
  localparam logic signed [RND_WIDTH-1:0] SAT_MAX = RND_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RND_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [SHIFT_WIDTH-1:0]  shift_reg;
  logic [BIAS_WIDTH-1:0]   bias_reg;
  logic                    relu_reg;
  logic [CNT_WIDTH-1:0]    total_reg;
  logic [CNT_WIDTH-1:0]    accept_cnt_reg;
  logic [ADDR_WIDTH-1:0]   offset_reg;
  logic                    s1_valid_reg;
  logic [SUM_WIDTH-1:0]    s1_sum_reg;
  logic                    s2_valid_reg;
  logic [DATA_WIDTH-1:0]   s2_data_reg;
  logic [15:0]             sat_cnt_reg;

  logic                    stall;
  logic                    xfer;
  logic                    start_ok;
  logic [SUM_WIDTH-1:0]    s1_sum_next;
  logic [RND_WIDTH-1:0]    half;
  logic signed [RND_WIDTH-1:0] rnd_sum;
  logic signed [RND_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]   q_data;
  logic                    sat_hit;

  assign stall    = s2_valid_reg && !wr_ready;
  assign xfer     = acc_valid && acc_ready;
  assign start_ok = (state_reg == IDLE) && start;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept_cnt_reg == total_reg) state_next = DRAIN;
      // Leave as the final write fires so done lands on the following cycle.
      DRAIN:   if (!s1_valid_reg && (!s2_valid_reg || wr_ready)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    acc_ready = (state_reg == RUN) && !stall && (accept_cnt_reg < total_reg);
    busy      = (state_reg == RUN) || (state_reg == DRAIN);
    done      = (state_reg == DONE);
  end

  // Datapath: S1 sum, S2 rounding / saturation / ReLU
  always_comb begin
    s1_sum_next = {acc_in[ACC_WIDTH-1], acc_in}
                + {{(SUM_WIDTH - BIAS_WIDTH){bias_reg[BIAS_WIDTH-1]}}, bias_reg};
    half    = (RND_WIDTH'(1) << shift_reg) >> 1;
    rnd_sum = $signed({s1_sum_reg[SUM_WIDTH-1], s1_sum_reg}) + $signed(half);
    shifted = rnd_sum >>> shift_reg;
    q_data  = shifted[DATA_WIDTH-1:0];
    sat_hit = 1'b0;
    if (shifted > SAT_MAX) begin
      q_data  = SAT_MAX[DATA_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      q_data  = SAT_MIN[DATA_WIDTH-1:0];
      sat_hit = !relu_reg;
    end
    if (relu_reg && q_data[DATA_WIDTH-1]) q_data = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg  <= '0;
      shift_reg <= '0;
      bias_reg  <= '0;
      relu_reg  <= 1'b0;
      total_reg <= '0;
    end else if (start_ok) begin
      base_reg  <= cfg_base_addr;
      shift_reg <= cfg_shift;
      bias_reg  <= cfg_bias;
      relu_reg  <= cfg_relu_en;
      total_reg <= CNT_WIDTH'(cfg_out_w) * CNT_WIDTH'(cfg_out_h);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt_reg <= '0;
      offset_reg     <= '0;
      s1_valid_reg   <= 1'b0;
      s1_sum_reg     <= '0;
      s2_valid_reg   <= 1'b0;
      s2_data_reg    <= '0;
      sat_cnt_reg    <= '0;
    end else if (start_ok) begin
      // Pipeline is already empty in IDLE; only the frame counters need clearing.
      accept_cnt_reg <= '0;
      offset_reg     <= '0;
      sat_cnt_reg    <= '0;
    end else begin
      if (xfer) accept_cnt_reg <= accept_cnt_reg + 1'b1;
      if (s2_valid_reg && wr_ready) offset_reg <= offset_reg + 1'b1;
      if (!stall) begin
        s1_valid_reg <= xfer;
        if (xfer) s1_sum_reg <= s1_sum_next;
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= q_data;
          if (sat_hit && (sat_cnt_reg != 16'hFFFF)) sat_cnt_reg <= sat_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign wr_en   = s2_valid_reg;
  assign wr_addr = base_reg + offset_reg;
  assign wr_data = s2_data_reg;
  assign sat_cnt = sat_cnt_reg;

endmodule

// File: tb/tb_acc_requant_writeback.sv
// Directed bench for acc_requant_writeback: frames, rounding, saturation, stalls, wrap, reset.
module tb_acc_requant_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] cfg_base_addr = '0;
  logic [5:0]  cfg_out_w = '0;
  logic [5:0]  cfg_out_h = '0;
  logic [4:0]  cfg_shift = '0;
  logic [15:0] cfg_bias = '0;
  logic        cfg_relu_en = 1'b0;
  logic        acc_valid = 1'b0;
  logic [25:0] acc_in = '0;
  logic        acc_ready;
  logic        wr_ready = 1'b1;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic [15:0] sat_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  logic [10:0] q_addr[$];
  logic [7:0]  q_data[$];
  logic [25:0] vec[0:7];

  acc_requant_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
    .cfg_shift(cfg_shift), .cfg_bias(cfg_bias), .cfg_relu_en(cfg_relu_en),
    .acc_valid(acc_valid), .acc_in(acc_in), .acc_ready(acc_ready),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en && wr_ready) begin
        q_addr.push_back(wr_addr);
        q_data.push_back(wr_data);
        last_wr_cyc = cyc;
        $display("write addr=%0d data=%0d", wr_addr, $signed(wr_data));
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_frame(input logic [10:0] base, input logic [5:0] w, input logic [5:0] h,
                             input logic [4:0] sh, input logic [15:0] bias, input logic relu);
    q_addr.delete();
    q_data.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_out_w = w; cfg_out_h = h;
    cfg_shift = sh; cfg_bias = bias; cfg_relu_en = relu;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      got = 1'b0;
      acc_valid = 1'b1;
      acc_in = vec[i];
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (acc_ready) got = 1'b1;
        @(posedge clk); #1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL feed_accept: transfer %0d not accepted, acc_ready=%b required 1", i, acc_ready);
      end
    end
    acc_valid = 1'b0;
  endtask

  task automatic wait_done;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done_cnt > 0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done_cnt=%0d required 1", done_cnt);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({acc_ready, wr_en, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/wr_en/busy/done=%b required 0000", {acc_ready, wr_en, busy, done});
    end
    checks++;
    if ({wr_addr, wr_data, sat_cnt} !== 35'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d data=%0d sat=%0d required 0", wr_addr, wr_data, sat_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset done");
  endtask

  task automatic test_basic;
    logic [10:0] ea[4];
    logic [7:0]  ed[4];
    ea = '{11'd100, 11'd101, 11'd102, 11'd103};
    ed = '{8'h01, 8'hFE, 8'h03, 8'h7F};
    vec[0] = 26'd1; vec[1] = -26'd2; vec[2] = 26'd3; vec[3] = 26'd127;
    start_frame(11'd100, 6'd2, 6'd2, 5'd0, 16'd0, 1'b0);
    feed(4);
    wait_done();
    checks++;
    if (q_addr.size() != 4) begin
      errors++;
      $display("FAIL basic_count: writes=%0d required 4", q_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
          errors++;
          $display("FAIL basic_write%0d: got (%0d,%h) required (%0d,%h)", i, q_addr[i], q_data[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (done_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_timing: done cycle %0d required %0d", done_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (sat_cnt !== 16'd0 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_sat_done: sat_cnt=%0d dones=%0d required 0 and 1", sat_cnt, done_cnt);
    end
  endtask

  task automatic test_rounding;
    vec[0] = 26'd24; vec[1] = -26'd41;
    start_frame(11'd10, 6'd2, 6'd1, 5'd4, 16'd8, 1'b0);
    feed(2);
    wait_done();
    checks++;
    if (q_data.size() != 2) begin
      errors++;
      $display("FAIL round_count: writes=%0d required 2", q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 8'h02) begin
        errors++;
        $display("FAIL round_pos: data=%h required 02", q_data[0]);
      end
      checks++;
      if (q_data[1] !== 8'hFE) begin
        errors++;
        $display("FAIL round_neg: data=%h required fe", q_data[1]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] ed0[3];
    logic [7:0] ed1[3];
    ed0 = '{8'h7F, 8'h80, 8'hFB};
    ed1 = '{8'h7F, 8'h00, 8'h00};
    for (int r = 0; r < 2; r++) begin
      vec[0] = 26'd300; vec[1] = -26'd300; vec[2] = -26'd5;
      start_frame(11'd50, 6'd3, 6'd1, 5'd0, 16'd0, r[0]);
      feed(3);
      wait_done();
      checks++;
      if (q_data.size() != 3) begin
        errors++;
        $display("FAIL sat_count relu=%0d: writes=%0d required 3", r, q_data.size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (q_data[i] !== (r == 0 ? ed0[i] : ed1[i])) begin
            errors++;
            $display("FAIL sat_data relu=%0d idx=%0d: data=%h required %h", r, i, q_data[i], (r == 0 ? ed0[i] : ed1[i]));
          end
        end
      end
      checks++;
      if (sat_cnt !== (r == 0 ? 16'd2 : 16'd1)) begin
        errors++;
        $display("FAIL sat_cnt relu=%0d: sat_cnt=%0d required %0d", r, sat_cnt, (r == 0 ? 2 : 1));
      end
    end
  endtask

  task automatic test_backpressure;
    vec[0] = 26'd10; vec[1] = 26'd20; vec[2] = 26'd30; vec[3] = 26'd40;
    start_frame(11'd200, 6'd4, 6'd1, 5'd0, 16'd0, 1'b0);
    fork
      feed(4);
      begin
        repeat (2) @(posedge clk);
        #1 wr_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checks++;
          if (wr_en !== 1'b1 || wr_addr !== 11'd200 || wr_data !== 8'd10 || acc_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold c=%0d: en=%b addr=%0d data=%0d ready=%b required 1,200,10,0",
                     c, wr_en, wr_addr, wr_data, acc_ready);
          end
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
      end
    join
    wait_done();
    checks++;
    if (q_addr.size() != 4) begin
      errors++;
      $display("FAIL stall_count: writes=%0d required 4", q_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_addr[i] !== 11'(200 + i) || q_data[i] !== 8'(10 * (i + 1))) begin
          errors++;
          $display("FAIL stall_write%0d: got (%0d,%0d) required (%0d,%0d)", i, q_addr[i], q_data[i], 200 + i, 10 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [10:0] ea[3];
    ea = '{11'd2046, 11'd2047, 11'd0};
    vec[0] = 26'd5; vec[1] = 26'd6; vec[2] = 26'd7;
    start_frame(11'd2046, 6'd3, 6'd1, 5'd0, 16'd0, 1'b0);
    fork
      feed(3);
      begin
        @(posedge clk); #1;
        cfg_base_addr = 11'd5; cfg_out_w = 6'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done();
    checks++;
    if (q_addr.size() != 3 || done_cnt != 1) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d dones=%0d required 3 and 1", q_addr.size(), done_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_addr[i] !== ea[i] || q_data[i] !== 8'(5 + i)) begin
          errors++;
          $display("FAIL wrap_write%0d: got (%0d,%0d) required (%0d,%0d)", i, q_addr[i], q_data[i], ea[i], 5 + i);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    vec[0] = 26'd1; vec[1] = 26'd2;
    start_frame(11'd300, 6'd4, 6'd1, 5'd0, 16'd0, 1'b0);
    feed(2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_ready, wr_en, busy, done} !== 4'b0000 || {wr_addr, wr_data, sat_cnt} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b addr=%0d data=%0d sat=%0d required all 0",
               {acc_ready, wr_en, busy, done}, wr_addr, wr_data, sat_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL mid_no_done: dones=%0d required 0", done_cnt);
    end
    vec[0] = 26'd9; vec[1] = 26'd10;
    start_frame(11'd400, 6'd2, 6'd1, 5'd0, 16'd0, 1'b0);
    feed(2);
    wait_done();
    checks++;
    if (q_addr.size() != 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_restart_count: writes=%0d dones=%0d required 2 and 1", q_addr.size(), done_cnt);
    end else begin
      checks++;
      if (q_addr[0] !== 11'd400 || q_data[0] !== 8'd9 || q_addr[1] !== 11'd401 || q_data[1] !== 8'd10) begin
        errors++;
        $display("FAIL mid_restart_data: got (%0d,%0d),(%0d,%0d) required (400,9),(401,10)",
                 q_addr[0], q_data[0], q_addr[1], q_data[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
